ifetch_unit: RTL and testbench

//  Instruction fetch stage. Owns the program counter, drives the instruction memory address and

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_perf_ctr.sv | 37 +++
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
//   Shared definitions for the instruction fetch stage: default widths, the
//   reset fetch address and the fetch state encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int         IFETCH_ADDR_W   = 8;
    localparam int         IFETCH_DATA_W   = 8;
    localparam logic [7:0] IFETCH_RESET_PC = 8'h00;

    // BOOT: first issue after reset; RUN: issuing every cycle; HALT: issue stopped.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_perf_ctr.sv
// ----------------------------------------------------------------------------
// ifetch_perf_ctr
//   16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous, active-low clear
//     inc    in   count one event this cycle
//     count  out  current count
// ----------------------------------------------------------------------------
module ifetch_perf_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch stage. Owns the PC, drives the instruction memory
//   address, absorbs the memory's 1-cycle read latency and hands each fetched
//   instruction to decode over a valid/ready handshake. Supports stall,
//   branch redirect, halt and silent PC wrap-around.
//   Optional feature macro: IFETCH_PERF_EN (adds fetch_count / stall_count).
//   Ports:
//     clk            in   rising-edge clock
//     reset          in   synchronous, active-low
//     imem_addr      out  address sampled by instruction memory at next edge
//     imem_data      in   memory read data, one cycle after its address
//     instr          out  instruction presented to decode
//     instr_pc       out  address of instr
//     instr_valid    out  instr / instr_pc valid
//     instr_ready    in   decode accepts when valid & ready
//     redirect_valid in   taken branch/jump pulse
//     redirect_pc    in   redirect target
//     halt           in   stop fetching after the instruction in flight
//     fetch_count    out  (IFETCH_PERF_EN) accepted instructions, saturating
//     stall_count    out  (IFETCH_PERF_EN) valid-but-not-ready cycles, saturating
// ----------------------------------------------------------------------------
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = IFETCH_ADDR_W,
    parameter int                DATA_W   = IFETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count
`endif
);

    ifetch_state_e     state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] addr_sel;
    logic              stall;

    // Decode holds a valid instruction: keep re-reading that word so
    // imem_data stays stable until it is taken.
    assign stall = resp_valid_q & ~instr_ready;

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path
        // leaves it unassigned and no latch is inferred.
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        state_d      = state_q;
        addr_sel     = resp_pc_q;

        if (redirect_valid) begin
            addr_sel     = redirect_pc;
            resp_pc_d    = redirect_pc;
            resp_valid_d = 1'b1;
            fetch_pc_d   = redirect_pc + ADDR_W'(1);
            state_d      = RUN;
        end else if (stall) begin
            // Address already points at resp_pc; only the halt request moves.
            if ((state_q == RUN) && halt) begin
                state_d = HALT;
            end
        end else if ((state_q == BOOT) || (state_q == RUN)) begin
            addr_sel     = fetch_pc_q;
            resp_pc_d    = fetch_pc_q;
            resp_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
            // Halt is ignored in BOOT; the fetch issued this cycle still lands.
            state_d      = ((state_q == RUN) && halt) ? HALT : RUN;
        end else begin
            // Halted and not stalled: the held instruction (if any) was taken.
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; state uses
        // non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            state_q      <= BOOT;
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // While reset is held the outputs are forced, so they are clean even
    // before the first reset edge and regardless of redirect inputs.
    assign imem_addr   = reset ? addr_sel  : RESET_PC;
    assign instr_pc    = reset ? resp_pc_q : RESET_PC;
    assign instr       = imem_data;
    // A same-cycle redirect kills the wrong-path instruction on the bus.
    assign instr_valid = reset & resp_valid_q & ~redirect_valid;

`ifdef IFETCH_PERF_EN
    logic accept_evt;
    logic stall_evt;

    assign accept_evt = instr_valid & instr_ready;
    assign stall_evt  = instr_valid & ~instr_ready;

    ifetch_perf_ctr u_fetch_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (accept_evt),
        .count (fetch_count)
    );

    ifetch_perf_ctr u_stall_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
//   Self-checking bench for ifetch_unit with a behavioural 1-cycle memory
//   (mem[a] = a ^ 8'h5A). The reference model tracks, per cycle, which
//   instruction decode should see and which address is being fetched for the
//   following cycle.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt = 1'b0;
`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: instruction on the decode bus and fetch permission.
    logic [7:0]  m_pc    = RST_PC;
    logic        m_valid = 1'b0;
    logic        m_fetch = 1'b1;
    logic        m_boot  = 1'b1;
    logic [15:0] m_fcnt  = 16'd0;
    logic [15:0] m_scnt  = 16'd0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= imem_addr ^ 8'h5A;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, compare against the
    // model, then advance the model across the rising edge.
    task automatic cycle(input logic r, input logic rdy, input logic rv,
                         input logic [7:0] rpc, input logic h);
        logic [7:0] exp_addr;
        logic       vis;
        @(negedge clk);
        reset          = r;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        #1;
        vis = r && m_valid && !rv;
        // The fetched address is whatever decode should see next cycle.
        if (!r)                   exp_addr = RST_PC;
        else if (rv)              exp_addr = rpc;
        else if (m_valid && !rdy) exp_addr = m_pc;
        else if (m_fetch)         exp_addr = m_valid ? m_pc + 8'd1 : m_pc;
        else                      exp_addr = m_pc;
        check("valid", {15'd0, instr_valid}, {15'd0, vis});
        if (!r) begin
            check("rst_pc", {8'd0, instr_pc}, {8'd0, RST_PC});
        end else if (vis) begin
            check("pc", {8'd0, instr_pc}, {8'd0, m_pc});
            check("instr", {8'd0, instr}, {8'd0, m_pc ^ 8'h5A});
        end
        check("addr", {8'd0, imem_addr}, {8'd0, exp_addr});
`ifdef IFETCH_PERF_EN
        check("fetch_count", fetch_count, m_fcnt);
        check("stall_count", stall_count, m_scnt);
`endif
        @(posedge clk);
        if (!r) begin
            m_pc = RST_PC; m_valid = 1'b0; m_fetch = 1'b1; m_boot = 1'b1;
            m_fcnt = 16'd0; m_scnt = 16'd0;
        end else begin
            if (vis && rdy && m_fcnt != 16'hFFFF)  m_fcnt = m_fcnt + 16'd1;
            if (vis && !rdy && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            if (rv) begin
                m_pc = rpc; m_valid = 1'b1; m_fetch = 1'b1; m_boot = 1'b0;
            end else if (m_valid && !rdy) begin
                if (h) m_fetch = 1'b0;
            end else if (m_fetch) begin
                if (m_valid) m_pc = m_pc + 8'd1;
                m_valid = 1'b1;
                if (h && !m_boot) m_fetch = 1'b0;
                m_boot = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Free-run with ready=1 until the model presents pc next cycle; bounded.
    task automatic run_to(input logic [7:0] pc);
        for (int n = 0; n < 400 && !(m_valid && m_pc == pc); n++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        #1;
        check("run_to", {8'd0, instr_pc}, {8'd0, pc});
    endtask

    initial begin
        // Reset held: outputs forced.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Release; first cycle invalid, then 00, 01, ... up to 04.
        run_to(8'h04);

        // Stall on 04 for three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            #1;
            check("stall_instr", {8'd0, instr}, 16'h005E);
            check("stall_pc", {8'd0, instr_pc}, 16'h0004);
            check("stall_addr", {8'd0, imem_addr}, 16'h0004);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        check("after_stall_pc", {8'd0, instr_pc}, 16'h0005);

        // Redirect to 80 while 10 is on the bus.
        run_to(8'h10);
        cycle(1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
        #1;
        check("redir_pc", {8'd0, instr_pc}, 16'h0080);
        check("redir_instr", {8'd0, instr}, 16'h00DA);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        check("redir_next", {8'd0, instr_pc}, 16'h0081);

        // Wrap: FE, FF, 00, 01.
        cycle(1'b1, 1'b1, 1'b1, 8'hFE, 1'b0);
        #1; check("wrap_fe", {8'd0, instr_pc}, 16'h00FE);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1; check("wrap_ff", {8'd0, instr_pc}, 16'h00FF);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1; check("wrap_00", {8'd0, instr_pc}, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1; check("wrap_01", {8'd0, instr_pc}, 16'h0001);

        // Halt at 20: 21 still delivered, then nothing until redirect to 40.
        run_to(8'h20);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        #1; check("halt_last", {8'd0, instr_pc}, 16'h0021);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1; check("halted_valid", {15'd0, instr_valid}, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
        #1; check("resume_pc", {8'd0, instr_pc}, 16'h0040);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset mid-stream at 33, then restart at RESET_PC.
        run_to(8'h33);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        check("midrst_valid", {15'd0, instr_valid}, 16'h0000);
`ifdef IFETCH_PERF_EN
        check("midrst_fcnt", fetch_count, 16'h0000);
        check("midrst_scnt", stall_count, 16'h0000);
`endif
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #1; check("restart_pc", {8'd0, instr_pc}, {8'd0, RST_PC});
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(99) != 0),
                  ($urandom_range(3) != 0),
                  ($urandom_range(19) == 0),
                  8'($urandom),
                  ($urandom_range(29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
